prog_mem_arbiter: RTL and testbench
===================================

# prog_mem_arbiter

Round-robin arbiter that shares one program-memory read port among NUM_CONSUMERS instruction-cache miss ports, one per core. It sits between the per-core icache memory-side interfaces and the program memory. Each consumer holds a valid/address pair until the arbiter returns ready with data. The arbiter also counts contention cycles for performance analysis.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, address width
- PROGRAM_MEM_DATA_BITS, 16, instruction width
- NUM_CONSUMERS, 4, number of icache miss ports (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request, held until serviced
- consumer_read_address  in  NUM_CONSUMERS×ADDR_BITS  packed; consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  per-consumer completion; at most one bit set
- consumer_read_data  out  NUM_CONSUMERS×DATA_BITS  packed; slice i valid while ready[i]=1
- mem_read_valid  out  1  program-memory request
- mem_read_address  out  ADDR_BITS  program-memory address
- mem_read_ready  in  1  memory completion, qualifies mem_read_data
- mem_read_data  in  DATA_BITS  program-memory read data
- busy  out  1  high in any state other than IDLE
- contention_cycles  out  32  saturating count of lost-arbitration cycles

## Operation
- FSM states: IDLE, WAITING, RELAYING.
- IDLE: scan consumer_read_valid starting at rr_ptr, wrapping modulo NUM_CONSUMERS. The first set bit becomes owner.
  - Latch its address into mem_read_address and set mem_read_valid=1.
  - Set rr_ptr <= (owner+1) mod NUM_CONSUMERS, then go to WAITING.
  - If no bit is set, stay in IDLE.
- WAITING: hold mem_read_valid and the address.
  - On mem_read_ready=1: mem_read_valid<=0, latch mem_read_data into the owner's data slice, set consumer_read_ready[owner]<=1, go to RELAYING.
- RELAYING: when consumer_read_valid[owner]=0, clear consumer_read_ready[owner] and return to IDLE. Otherwise hold.
- mem_read_ready is ignored in IDLE and RELAYING.
- If the owner drops valid during WAITING, the memory transaction still completes. Ready is asserted for exactly one cycle in RELAYING, then the FSM returns to IDLE.
- The owner's address change after grant has no effect; the latched address is used.
- Data slices of non-owners retain their last value.
- contention_cycles increments by 1 in every cycle where at least one consumer has valid=1 and is not the current owner (IDLE has no owner). It saturates at 0xFFFF_FFFF.

## Timing
- Reset values: consumer_read_ready=0, consumer_read_data=0, mem_read_valid=0, mem_read_address=0, busy=0, contention_cycles=0, rr_ptr=0, state IDLE.
- Reset mid-transaction aborts immediately. Memory must tolerate valid dropping without ready.
- Latency:
  - Request sampled in IDLE at edge T → mem_read_valid high after edge T.
  - mem_read_ready sampled at edge R → consumer_read_ready high after edge R.
  - Best case is valid at T, ready visible at T+2 with a 1-cycle memory.
- Grant turnaround: the next grant can occur at the edge after the cycle in which the FSM is back in IDLE. That is one IDLE cycle minimum between transactions.
- Fairness: with all consumers requesting continuously, grant order is 0,1,2,…,N-1,0,… No consumer waits more than N-1 transactions.
- NUM_CONSUMERS=1: rr_ptr is constant 0.

## Test plan
- Single request: reset, consumer 2 valid with address 0x3A, memory returns 0xBEEF one cycle after request → mem_read_address=0x3A, ready[2]=1 with data slice 2=0xBEEF; drop valid → ready clears, busy=0.
- All four request simultaneously (addresses 0x10,0x20,0x30,0x40), each held until ready → grants in order 0,1,2,3. Memory sees addresses in that order. contention_cycles equals the summed non-owner waiting cycles.
- Pointer wrap: after consumer 3 is served, consumers 0 and 3 request together → consumer 0 wins.
- Owner drops valid during WAITING → memory transaction completes, ready pulses one cycle, FSM returns to IDLE.
- Spurious mem_read_ready in IDLE → no ready output and no state change.
- Reset asserted in WAITING → all outputs zero asynchronously. After release, rr_ptr=0 and a fresh request from consumer 1 is served normally.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_arbiter
// Brief    : Round-robin arbiter sharing one program-memory read port among
//            per-core icache miss ports, with a contention-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem_arbiter #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int NUM_CONSUMERS         = 4
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_CONSUMERS-1:0]                         consumer_read_valid,
    input  logic [NUM_CONSUMERS*PROGRAM_MEM_ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                         consumer_read_ready,
    output logic [NUM_CONSUMERS*PROGRAM_MEM_DATA_BITS-1:0]   consumer_read_data,
    output logic                                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]                 mem_read_data,
    output logic                                             busy,
    output logic [31:0]                                      contention_cycles
);

    localparam int c_PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAITING  = 2'd1,
        ST_RELAYING = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_owner;

    logic                     w_found;
    logic [c_PTR_W-1:0]       w_pick;
    logic [c_PTR_W-1:0]       w_idx;
    logic [c_PTR_W-1:0]       w_next_ptr;
    logic [NUM_CONSUMERS-1:0] w_owner_mask;
    logic                     w_contend;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            w_idx = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_CONSUMERS);
            if (!w_found && consumer_read_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_next_ptr = (w_pick == c_PTR_W'(NUM_CONSUMERS - 1)) ? '0 : w_pick + 1'b1;

    // No owner exists in IDLE, so every pending request there counts as contention.
    always_comb begin
        w_owner_mask = '0;
        if (r_state != ST_IDLE) begin
            w_owner_mask[r_owner] = 1'b1;
        end
    end

    assign w_contend = |(consumer_read_valid & ~w_owner_mask);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_rr_ptr            <= '0;
            r_owner             <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            contention_cycles   <= '0;
        end else begin
            if (w_contend && (contention_cycles != 32'hFFFF_FFFF)) begin
                contention_cycles <= contention_cycles + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner          <= w_pick;
                        r_rr_ptr         <= w_next_ptr;
                        mem_read_address <= consumer_read_address[int'(w_pick)*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
                        mem_read_valid   <= 1'b1;
                        r_state          <= ST_WAITING;
                    end
                end
                ST_WAITING: begin
                    // Completes even if the owner has withdrawn its request.
                    if (mem_read_ready) begin
                        mem_read_valid               <= 1'b0;
                        consumer_read_data[int'(r_owner)*PROGRAM_MEM_DATA_BITS +: PROGRAM_MEM_DATA_BITS] <= mem_read_data;
                        consumer_read_ready[r_owner] <= 1'b1;
                        r_state                      <= ST_RELAYING;
                    end
                end
                ST_RELAYING: begin
                    if (!consumer_read_valid[r_owner]) begin
                        consumer_read_ready <= '0;
                        r_state             <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_arbiter
// Brief    : Directed self-checking bench for prog_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    valid;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ready;
    logic [N*DW-1:0] data;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic [DW-1:0]   mem_data;
    logic            busy;
    logic [31:0]     cont;

    int checks = 0;
    int errors = 0;

    prog_mem_arbiter #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .NUM_CONSUMERS(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(valid),
        .consumer_read_address(addr),
        .consumer_read_ready(ready),
        .consumer_read_data(data),
        .mem_read_valid(mem_valid),
        .mem_read_address(mem_addr),
        .mem_read_ready(mem_ready),
        .mem_read_data(mem_data),
        .busy(busy),
        .contention_cycles(cont)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        valid     = '0;
        mem_ready = 1'b0;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; valid = '0; addr = '0; mem_ready = 1'b0; mem_data = '0;
        #1 reset = 1'b1;
        #1;
        checks++; if (ready !== 4'b0)     begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (data !== '0)        begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (mem_addr !== 8'h0)  begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cont !== 32'd0)     begin errors++; $display("FAIL reset_cont: got %0d expected 0", cont); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single;
        valid = 4'b0100;
        addr[2*AW +: AW] = 8'h3A;
        tick();
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_mem_valid: got %b expected 1", mem_valid); end
        checks++; if (mem_addr !== 8'h3A) begin errors++; $display("FAIL single_mem_addr: got %h expected 3a", mem_addr); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if (ready !== 4'b0)     begin errors++; $display("FAIL single_early_ready: got %b expected 0", ready); end
        addr[2*AW +: AW] = 8'h99;
        mem_ready = 1'b1; mem_data = 16'hBEEF;
        tick();
        checks++; if (ready !== 4'b0100)            begin errors++; $display("FAIL single_ready: got %b expected 0100", ready); end
        checks++; if (data[2*DW +: DW] !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h expected beef", data[2*DW +: DW]); end
        checks++; if (mem_valid !== 1'b0)           begin errors++; $display("FAIL single_mem_drop: got %b expected 0", mem_valid); end
        checks++; if (mem_addr !== 8'h3A)           begin errors++; $display("FAIL single_latched_addr: got %h expected 3a", mem_addr); end
        mem_ready = 1'b0; valid = '0;
        tick();
        checks++; if (ready !== 4'b0) begin errors++; $display("FAIL single_ready_clear: got %b expected 0", ready); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
        checks++; if (cont !== 32'd1) begin errors++; $display("FAIL single_cont: got %0d expected 1", cont); end
    endtask

    task automatic test_all_four;
        do_reset();
        addr  = {8'h40, 8'h30, 8'h20, 8'h10};
        valid = 4'hF;
        for (int g = 0; g < N; g++) begin
            int n;
            logic [AW-1:0] exp_a;
            logic [DW-1:0] exp_d;
            n = 0;
            exp_a = 8'((g + 1) * 16);
            exp_d = 16'hD000 | {8'h00, exp_a};
            tick();
            while (!mem_valid && n < 10) begin
                tick();
                n++;
            end
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL all4_grant%0d_timeout: got %b expected 1", g, mem_valid); end
            checks++; if (mem_addr !== exp_a) begin errors++; $display("FAIL all4_order%0d: got %h expected %h", g, mem_addr, exp_a); end
            mem_ready = 1'b1; mem_data = exp_d;
            tick();
            checks++; if (ready !== (4'b0001 << g))   begin errors++; $display("FAIL all4_ready%0d: got %b expected %b", g, ready, 4'b0001 << g); end
            checks++; if (data[g*DW +: DW] !== exp_d) begin errors++; $display("FAIL all4_data%0d: got %h expected %h", g, data[g*DW +: DW], exp_d); end
            mem_ready = 1'b0; valid[g] = 1'b0;
            tick();
            checks++; if (ready !== 4'b0) begin errors++; $display("FAIL all4_clear%0d: got %b expected 0", g, ready); end
        end
        checks++; if (cont !== 32'd10) begin errors++; $display("FAIL all4_cont: got %0d expected 10", cont); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL all4_idle: got %b expected 0", busy); end
    endtask

    task automatic test_pointer_wrap;
        addr[0*AW +: AW] = 8'h55;
        addr[3*AW +: AW] = 8'h66;
        valid = 4'b1001;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h55) begin errors++; $display("FAIL wrap_first: got %b/%h expected 1/55", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_data = 16'h0055;
        tick();
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b expected 0001", ready); end
        mem_ready = 1'b0; valid[0] = 1'b0;
        tick();
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h66) begin errors++; $display("FAIL wrap_second: got %b/%h expected 1/66", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_data = 16'h0066;
        tick();
        checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b expected 1000", ready); end
        mem_ready = 1'b0; valid = '0;
        tick();
    endtask

    task automatic test_owner_drop;
        do_reset();
        addr[1*AW +: AW] = 8'h21;
        valid = 4'b0010;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h21) begin errors++; $display("FAIL drop_grant: got %b/%h expected 1/21", mem_valid, mem_addr); end
        valid = '0;
        tick();
        checks++; if (mem_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL drop_hold: got %b/%b expected 1/1", mem_valid, busy); end
        mem_ready = 1'b1; mem_data = 16'h1234;
        tick();
        checks++; if (ready !== 4'b0010)              begin errors++; $display("FAIL drop_pulse: got %b expected 0010", ready); end
        checks++; if (data[1*DW +: DW] !== 16'h1234) begin errors++; $display("FAIL drop_data: got %h expected 1234", data[1*DW +: DW]); end
        mem_ready = 1'b0;
        tick();
        checks++; if (ready !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_end: got %b/%b expected 0000/0", ready, busy); end
    endtask

    task automatic test_spurious;
        mem_ready = 1'b1; mem_data = 16'hFFFF;
        tick();
        checks++; if (ready !== 4'b0)         begin errors++; $display("FAIL spur_ready: got %b expected 0", ready); end
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spur_state: got %b/%b expected 0/0", mem_valid, busy); end
        checks++; if (data !== 64'h0000_0000_1234_0000) begin errors++; $display("FAIL spur_data: got %h expected 0000000012340000", data); end
        checks++; if (cont !== 32'd1)         begin errors++; $display("FAIL spur_cont: got %0d expected 1", cont); end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_waiting;
        addr[1*AW +: AW] = 8'h42;
        addr[3*AW +: AW] = 8'h77;
        valid = 4'b0010;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h42) begin errors++; $display("FAIL rstw_grant: got %b/%h expected 1/42", mem_valid, mem_addr); end
        reset = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0 || mem_addr !== 8'h0) begin errors++; $display("FAIL rstw_mem: got %b/%h expected 0/00", mem_valid, mem_addr); end
        checks++; if (ready !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_ctl: got %b/%b expected 0000/0", ready, busy); end
        checks++; if (data !== '0 || cont !== 32'd0)   begin errors++; $display("FAIL rstw_regs: got %h/%0d expected 0/0", data, cont); end
        tick();
        reset = 1'b0;
        valid = 4'b1010;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h42) begin errors++; $display("FAIL rstw_ptr: got %b/%h expected 1/42", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_data = 16'h4242;
        tick();
        checks++; if (ready !== 4'b0010 || data[1*DW +: DW] !== 16'h4242) begin errors++; $display("FAIL rstw_serve: got %b/%h expected 0010/4242", ready, data[1*DW +: DW]); end
        mem_ready = 1'b0; valid = '0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_idle: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_pointer_wrap();
        test_owner_drop();
        test_spurious();
        test_reset_waiting();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
